mem_lsu: RTL and testbench

Multi-cycle load/store unit between the execute stage and the `idram` DRAM port. Accepts one memory request per handshake, enforces natural alignment, and drives the DRAM strobes, 8-byte-aligned address, lane-shifted write data and byte mask. It extracts and sign/zero-extends load data and returns a one-cycle response pulse. With today's combinational DPI-C DRAM, `lsu_mem_ack_i` is tied high; the ack input exists so a wait-state memory can replace it without changes here.

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_align.sv | 49 ++++
 rtl/mem_lsu.sv | 141 ++++++++++++++
 tb/tb_mem_lsu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane-alignment helper.
package mem_lsu_pkg;

  localparam int DATABUS_WIDTH = 64;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'b00,
    LSU_SIZE_H = 2'b01,
    LSU_SIZE_W = 2'b10,
    LSU_SIZE_D = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_ACCESS = 2'b01,
    LSU_RESP   = 2'b10
  } lsu_state_e;

  function automatic logic [7:0] lsu_base_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      LSU_SIZE_B: mask = 8'h01;
      LSU_SIZE_H: mask = 8'h03;
      LSU_SIZE_W: mask = 8'h0F;
      default:    mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: misalign detect, byte mask, store-data shift and
// load extract with sign/zero extension.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DW = DATABUS_WIDTH
) (
  input  logic [1:0]    chk_size,
  input  logic [2:0]    chk_off,
  output logic          misalign,
  input  logic [1:0]    size,
  input  logic [2:0]    off,
  input  logic          zext,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] busrdata,
  output logic [7:0]    wmask,
  output logic [DW-1:0] buswdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] rshift;

  // Misalign is checked on the incoming request, before it is latched.
  always_comb begin
    case (chk_size)
      LSU_SIZE_H: misalign = chk_off[0];
      LSU_SIZE_W: misalign = |chk_off[1:0];
      LSU_SIZE_D: misalign = |chk_off;
      default:    misalign = 1'b0;
    endcase
  end

  assign wmask    = lsu_base_mask(size) << off;
  assign buswdata = wdata << {off, 3'b000};
  assign rshift   = busrdata >> {off, 3'b000};

  always_comb begin
    case (size)
      LSU_SIZE_B: rdata = zext ? {{(DW-8){1'b0}}, rshift[7:0]}
                               : {{(DW-8){rshift[7]}}, rshift[7:0]};
      LSU_SIZE_H: rdata = zext ? {{(DW-16){1'b0}}, rshift[15:0]}
                               : {{(DW-16){rshift[15]}}, rshift[15:0]};
      LSU_SIZE_W: rdata = zext ? {{(DW-32){1'b0}}, rshift[31:0]}
                               : {{(DW-32){rshift[31]}}, rshift[31:0]};
      default:    rdata = rshift;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Multi-cycle load/store unit: request latch, IDLE/ACCESS/RESP sequencer and
// response registers in front of the DRAM port.
//
//   state      | meaning
//   LSU_IDLE   | ready; accept and latch a request
//   LSU_ACCESS | drive DRAM strobes until ack
//   LSU_RESP   | one-cycle response pulse
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DW = DATABUS_WIDTH
) (
  input  logic          lsu_clk_i,
  input  logic          lsu_rst_n_i,
  input  logic          lsu_req_valid_i,
  output logic          lsu_req_ready_o,
  input  logic          lsu_req_store_i,
  input  logic [1:0]    lsu_req_size_i,
  input  logic          lsu_req_unsigned_i,
  input  logic [DW-1:0] lsu_req_addr_i,
  input  logic [DW-1:0] lsu_req_wdata_i,
  input  logic [DW-1:0] lsu_req_pc_i,
  output logic          lsu_rsp_valid_o,
  output logic [DW-1:0] lsu_rsp_rdata_o,
  output logic          lsu_rsp_misalign_o,
  output logic          lsu_mem_wen_o,
  output logic          lsu_mem_ren_o,
  output logic [DW-1:0] lsu_mem_rwaddr_o,
  output logic [DW-1:0] lsu_mem_buswdata_o,
  output logic [7:0]    lsu_mem_wmask_o,
  output logic [DW-1:0] lsu_mem_pc_o,
  input  logic [DW-1:0] lsu_mem_busrdata_i,
  input  logic          lsu_mem_ack_i
);

  lsu_state_e    state_q, state_d;

  logic          lat_store;
  logic [1:0]    lat_size;
  logic          lat_zext;
  logic [DW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] lat_pc;

  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_misalign_q;

  logic          req_misalign;
  logic [7:0]    al_wmask;
  logic [DW-1:0] al_buswdata;
  logic [DW-1:0] al_rdata;
  logic          accept;

  assign accept = lsu_req_valid_i && (state_q == LSU_IDLE);

  lsu_align #(.DW(DW)) u_align (
    .chk_size (lsu_req_size_i),
    .chk_off  (lsu_req_addr_i[2:0]),
    .misalign (req_misalign),
    .size     (lat_size),
    .off      (lat_addr[2:0]),
    .zext     (lat_zext),
    .wdata    (lat_wdata),
    .busrdata (lsu_mem_busrdata_i),
    .wmask    (al_wmask),
    .buswdata (al_buswdata),
    .rdata    (al_rdata)
  );

  always_ff @(posedge lsu_clk_i or negedge lsu_rst_n_i) begin
    if (!lsu_rst_n_i) state_q <= LSU_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:   if (lsu_req_valid_i) state_d = req_misalign ? LSU_RESP : LSU_ACCESS;
      LSU_ACCESS: if (lsu_mem_ack_i)   state_d = LSU_RESP;
      LSU_RESP:   state_d = LSU_IDLE;
      default:    state_d = LSU_IDLE;
    endcase
  end

  // Memory-facing outputs are forced to zero outside ACCESS so the DPI side
  // never sees a stale address or strobe.
  always_comb begin
    lsu_req_ready_o    = 1'b0;
    lsu_rsp_valid_o    = 1'b0;
    lsu_rsp_rdata_o    = '0;
    lsu_rsp_misalign_o = 1'b0;
    lsu_mem_wen_o      = 1'b0;
    lsu_mem_ren_o      = 1'b0;
    lsu_mem_rwaddr_o   = '0;
    lsu_mem_buswdata_o = '0;
    lsu_mem_wmask_o    = '0;
    lsu_mem_pc_o       = '0;
    case (state_q)
      LSU_IDLE: lsu_req_ready_o = 1'b1;
      LSU_ACCESS: begin
        lsu_mem_wen_o      = lat_store;
        lsu_mem_ren_o      = !lat_store;
        lsu_mem_rwaddr_o   = {lat_addr[DW-1:3], 3'b000};
        lsu_mem_buswdata_o = al_buswdata;
        lsu_mem_wmask_o    = al_wmask;
        lsu_mem_pc_o       = lat_pc;
      end
      LSU_RESP: begin
        lsu_rsp_valid_o    = 1'b1;
        lsu_rsp_rdata_o    = rsp_rdata_q;
        lsu_rsp_misalign_o = rsp_misalign_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lsu_clk_i or negedge lsu_rst_n_i) begin
    if (!lsu_rst_n_i) begin
      lat_store      <= 1'b0;
      lat_size       <= '0;
      lat_zext       <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_pc         <= '0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
    end else if (accept) begin
      lat_store      <= lsu_req_store_i;
      lat_size       <= lsu_req_size_i;
      lat_zext       <= lsu_req_unsigned_i;
      lat_addr       <= lsu_req_addr_i;
      lat_wdata      <= lsu_req_wdata_i;
      lat_pc         <= lsu_req_pc_i;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= req_misalign;
    end else if (state_q == LSU_ACCESS && lsu_mem_ack_i && !lat_store) begin
      rsp_rdata_q    <= al_rdata;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, misalign, ack stalls, mid-access reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_misalign;
  logic [63:0] rsp_rdata;
  logic        mem_wen, mem_ren, mem_ack;
  logic [63:0] mem_rwaddr, mem_buswdata, mem_pc, mem_busrdata;
  logic [7:0]  mem_wmask;

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_rd  = 0;

  mem_lsu dut (
    .lsu_clk_i          (clk),
    .lsu_rst_n_i        (rst_n),
    .lsu_req_valid_i    (req_valid),
    .lsu_req_ready_o    (req_ready),
    .lsu_req_store_i    (req_store),
    .lsu_req_size_i     (req_size),
    .lsu_req_unsigned_i (req_unsigned),
    .lsu_req_addr_i     (req_addr),
    .lsu_req_wdata_i    (req_wdata),
    .lsu_req_pc_i       (req_pc),
    .lsu_rsp_valid_o    (rsp_valid),
    .lsu_rsp_rdata_o    (rsp_rdata),
    .lsu_rsp_misalign_o (rsp_misalign),
    .lsu_mem_wen_o      (mem_wen),
    .lsu_mem_ren_o      (mem_ren),
    .lsu_mem_rwaddr_o   (mem_rwaddr),
    .lsu_mem_buswdata_o (mem_buswdata),
    .lsu_mem_wmask_o    (mem_wmask),
    .lsu_mem_pc_o       (mem_pc),
    .lsu_mem_busrdata_i (mem_busrdata),
    .lsu_mem_ack_i      (mem_ack)
  );

  always #5 clk = ~clk;

  // Count DRAM commits the way idram sees them: strobe and ack at a rising edge.
  always @(posedge clk) begin
    if (mem_wen && mem_ack) n_wr++;
    if (mem_ren && mem_ack) n_rd++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic zx,
                           input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = zx;
    req_addr = a; req_wdata = wd; req_pc = a + 64'h100;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] exp_addr,
                          input logic [7:0] exp_mask, input logic [63:0] exp_bus);
    drive_req(1'b1, sz, 1'b0, a, wd);
    @(negedge clk);
    chk({tag, "_wen"},      64'(mem_wen), 64'd1);
    chk({tag, "_ren"},      64'(mem_ren), 64'd0);
    chk({tag, "_ready"},    64'(req_ready), 64'd0);
    chk({tag, "_rwaddr"},   mem_rwaddr, exp_addr);
    chk({tag, "_wmask"},    64'(mem_wmask), 64'(exp_mask));
    chk({tag, "_buswdata"}, mem_buswdata, exp_bus);
    chk({tag, "_pc"},       mem_pc, a + 64'h100);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_wen"},   64'(mem_wen), 64'd0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic zx,
                         input logic [63:0] a, input logic [63:0] bus,
                         input logic [63:0] exp_rdata);
    mem_busrdata = bus;
    drive_req(1'b0, sz, zx, a, 64'h0);
    @(negedge clk);
    chk({tag, "_ren"},    64'(mem_ren), 64'd1);
    chk({tag, "_wen"},    64'(mem_wen), 64'd0);
    chk({tag, "_rwaddr"}, mem_rwaddr, {a[63:3], 3'b000});
    @(negedge clk);
    chk({tag, "_rsp_valid"},    64'(rsp_valid), 64'd1);
    chk({tag, "_rsp_misalign"}, 64'(rsp_misalign), 64'd0);
    chk({tag, "_rsp_rdata"},    rsp_rdata, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
    mem_busrdata = '0; mem_ack = 1'b1;
    #12;
    chk("rst_ready",  64'(req_ready), 64'd1);
    chk("rst_rsp",    64'(rsp_valid), 64'd0);
    chk("rst_strobe", 64'({mem_wen, mem_ren}), 64'd0);
    chk("rst_rwaddr", mem_rwaddr, 64'd0);
    chk("rst_wmask",  64'(mem_wmask), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_store("st_w", 2'b10, 64'h8000_0004, 64'h0000_0000_1122_3344,
             64'h8000_0000, 8'hF0, 64'h1122_3344_0000_0000);
    do_store("st_b7", 2'b00, 64'h8000_0007, 64'h0000_0000_0000_12AB,
             64'h8000_0000, 8'h80, 64'hAB00_0000_0000_0000);
    do_store("st_d", 2'b11, 64'h8000_0008, 64'h0102_0304_0506_0708,
             64'h8000_0008, 8'hFF, 64'h0102_0304_0506_0708);

    do_load("ld_bs", 2'b00, 1'b0, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("ld_bu", 2'b00, 1'b1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    do_load("ld_hs", 2'b01, 1'b0, 64'h8000_0006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("ld_wu", 2'b10, 1'b1, 64'h8000_0004, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000);
    do_load("ld_ws", 2'b10, 1'b0, 64'h8000_0004, 64'hF000_0000_1234_5678, 64'hFFFF_FFFF_F000_0000);

    // Misaligned half: response one cycle after accept, no memory access.
    drive_req(1'b0, 2'b01, 1'b0, 64'h8000_0001, 64'h0);
    @(negedge clk);
    chk("mis_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("mis_flag",      64'(rsp_misalign), 64'd1);
    chk("mis_rdata",     rsp_rdata, 64'd0);
    chk("mis_ren",       64'(mem_ren), 64'd0);
    @(negedge clk);
    chk("mis_rsp_gone",  64'(rsp_valid), 64'd0);

    // Double load with ack low for three ACCESS cycles.
    mem_ack = 1'b0;
    mem_busrdata = 64'h5555_5555_5555_5555;
    drive_req(1'b0, 2'b11, 1'b1, 64'h8000_0010, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_ren",    64'(mem_ren), 64'd1);
      chk("stall_rwaddr", mem_rwaddr, 64'h8000_0010);
      chk("stall_rsp",    64'(rsp_valid), 64'd0);
      chk("stall_ready",  64'(req_ready), 64'd0);
      mem_busrdata = 64'hA5A5_0000_0000_0000 + 64'(k);
    end
    @(negedge clk);
    chk("stall_ren_ack", 64'(mem_ren), 64'd1);
    mem_ack = 1'b1;
    mem_busrdata = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1 mem_busrdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("stall_rdata",     rsp_rdata, 64'h0123_4567_89AB_CDEF);

    // Reset in the middle of a store's ACCESS cycle.
    mem_ack = 1'b0;
    drive_req(1'b1, 2'b11, 1'b0, 64'h8000_0020, 64'hCAFE_F00D_CAFE_F00D);
    @(negedge clk);
    chk("rstmid_wen_before", 64'(mem_wen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_wen",    64'(mem_wen), 64'd0);
    chk("rstmid_ready",  64'(req_ready), 64'd1);
    chk("rstmid_rwaddr", mem_rwaddr, 64'd0);
    chk("rstmid_bus",    mem_buswdata, 64'd0);
    chk("rstmid_wmask",  64'(mem_wmask), 64'd0);
    chk("rstmid_pc",     mem_pc, 64'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
    chk("rstmid_idle",   64'(req_ready), 64'd1);

    chk("write_commits", 64'(n_wr), 64'd3);
    chk("read_commits",  64'(n_rd), 64'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
